// File: rtl/overlay_compositor.sv
// overlay_compositor: registered RGB222/sync output stage with animated text hue, blink and background gradient
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   hsync_in, vsync_in  active-low syncs from the sync generator
//   display_on          high inside the visible area
//   y                   current pixel row
//   overlay_active      text pixel flag from the overlay generator
//   cycle_en, blink_en  hue animation and text blink enables
//   hsync, vsync, r, g, b  registered VGA outputs, one clock behind the inputs
//   frame_count         frames elapsed, wraps at 256
module overlay_compositor #(
    parameter int CYCLE_FRAMES = 16,
    parameter int BLINK_BIT    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [9:0] y,
    input  logic       overlay_active,
    input  logic       cycle_en,
    input  logic       blink_en,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic [7:0] frame_count
);
    typedef enum logic [2:0] {RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA} hue_t;

    localparam logic [7:0] LAST = 8'(CYCLE_FRAMES - 1);

    hue_t       hue, hue_next;
    logic [7:0] sub, sub_next;
    logic       vs_prev, frame_edge, text_vis;
    logic [5:0] hue_rgb, pix;
    logic       unused_y;

    assign unused_y   = ^{y[9], y[6:0]};
    assign frame_edge = vs_prev & ~vsync_in;
    assign text_vis   = overlay_active & ~(blink_en & frame_count[BLINK_BIT]);

    always_comb begin
        hue_next = hue;
        sub_next = sub;
        if (frame_edge && cycle_en) begin
            if (sub == LAST) begin
                sub_next = 8'd0;
                hue_next = (hue == MAGENTA) ? RED : hue_t'(hue + 3'd1);
            end else begin
                sub_next = sub + 8'd1;
            end
        end
    end

    always_comb begin
        case (hue)
            YELLOW:  hue_rgb = 6'b11_11_00;
            GREEN:   hue_rgb = 6'b00_11_00;
            CYAN:    hue_rgb = 6'b00_11_11;
            BLUE:    hue_rgb = 6'b00_00_11;
            MAGENTA: hue_rgb = 6'b11_00_11;
            default: hue_rgb = 6'b11_00_00;
        endcase
    end

    // Pixel uses the pre-update hue and frame_count; blanking overrides everything
    assign pix = !display_on ? 6'd0 : text_vis ? hue_rgb : {4'd0, y[8:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hue <= RED;
        else
            hue <= hue_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            {r, g, b}   <= 6'd0;
            frame_count <= 8'd0;
            sub         <= 8'd0;
            vs_prev     <= 1'b1;
        end else begin
            hsync       <= hsync_in;
            vsync       <= vsync_in;
            {r, g, b}   <= pix;
            frame_count <= frame_count + {7'd0, frame_edge};
            sub         <= sub_next;
            vs_prev     <= vsync_in;
        end
    end
endmodule

// File: tb/tb_overlay_compositor.sv
// tb_overlay_compositor: randomized scoreboard bench for overlay_compositor against a frame-counting reference model
module tb_overlay_compositor;
    localparam int CF = 16;
    localparam int BB = 5;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, display_on = 1'b0;
    logic       overlay_active = 1'b0, cycle_en = 1'b0, blink_en = 1'b0;
    logic [9:0] y = '0;
    logic       hsync, vsync;
    logic [1:0] r, g, b;
    logic [7:0] frame_count;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
        logic [7:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_bad = 0;
    int   m_fc = 0, m_en = 0;
    bit   m_prev = 1'b1;

    overlay_compositor #(.CYCLE_FRAMES(CF), .BLINK_BIT(BB)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .y(y), .overlay_active(overlay_active),
        .cycle_en(cycle_en), .blink_en(blink_en), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Hue is a function of how many frame edges have been seen while animation was enabled
    function automatic logic [5:0] hue_of(int en_edges);
        case ((en_edges / CF) % 6)
            0: return 6'b110000;
            1: return 6'b111100;
            2: return 6'b001100;
            3: return 6'b001111;
            4: return 6'b000011;
            default: return 6'b110011;
        endcase
    endfunction

    task automatic step(bit rst, bit hs, bit vs, bit de, logic [9:0] yv, bit ov, bit ce, bit be);
        exp_t       e;
        bit         fe, vis;
        logic [5:0] rgb;
        @(negedge clk);
        rst_n = rst; hsync_in = hs; vsync_in = vs; display_on = de; y = yv;
        overlay_active = ov; cycle_en = ce; blink_en = be;
        if (!rst) begin
            m_fc = 0; m_en = 0; m_prev = 1'b1;
            e = '{1'b1, 1'b1, 6'd0, 8'd0};
        end else begin
            fe  = m_prev && !vs;
            vis = ov && !(be && m_fc[BB]);
            rgb = !de ? 6'd0 : vis ? hue_of(m_en) : {4'd0, yv[8:7]};
            if (fe) begin
                m_fc = (m_fc + 1) % 256;
                if (ce) m_en++;
            end
            m_prev = vs;
            e = '{hs, vs, rgb, 8'(m_fc)};
        end
        q.push_back(e);
    endtask

    task automatic px(bit rst, bit vs, bit ce, bit be);
        step(rst, 1'($urandom), vs, ($urandom % 4) != 0, 10'($urandom), 1'($urandom), ce, be);
    endtask

    task automatic frames(int n, bit ce, bit be);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) px(1'b1, 1'b0, ce, be);
            for (int k = 0; k < 3; k++) px(1'b1, 1'b1, ce, be);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({hsync, vsync, r, g, b, frame_count} !== {2'b11, 6'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got hs=%b vs=%b rgb=%h fc=%0d, want hs=1 vs=1 rgb=00 fc=0",
                     hsync, vsync, {r, g, b}, frame_count);
        end
        for (int i = 0; i < 3; i++) px(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {hsync, vsync, r, g, b, frame_count};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL out@%0t: got hs=%b vs=%b rgb=%h fc=%0d, want hs=%b vs=%b rgb=%h fc=%0d",
                             $time, a.hs, a.vs, a.rgb, a.fc, e.hs, e.vs, e.rgb, e.fc);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 20; i++) px(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 10'd0,   1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 10'd384, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'd384, 1'b1, 1'b0, 1'b0);
        frames(96, 1'b1, 1'b0);
        mid_reset();
        frames(10, 1'b1, 1'b0);
        frames(20, 1'b0, 1'b0);
        frames(6, 1'b1, 1'b0);
        mid_reset();
        frames(100, 1'b1, 1'b1);
        frames(256, 1'($urandom), 1'b1);
        for (int i = 0; i < 1000; i++) px(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) px(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) px(1'b1, 1'($urandom), ($urandom % 4) != 0, 1'($urandom));
        @(negedge clk);
        @(negedge clk);
        mid_reset();
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
